placement_slot_sequencer: RTL

//  Slot scheduler between the rectangle stream and the placement core. Samples one
//  (height,width) request per 4-cycle slot and hands it to the core via valid/ready.

---
 rtl/placement_pkg.sv | 25 ++
 rtl/place_fifo.sv | 45 ++++
 rtl/placement_slot_sequencer.sv | 111 +++++++++++
 3 files changed

// File: rtl/placement_pkg.sv
// Shared constants and request/result types for the placement slot sequencer.
package placement_pkg;
  localparam int SLOT_CYCLES   = 4;
  localparam int LATENCY_SLOTS = 2;
  localparam int DIM_W         = 5;
  localparam int IDX_W         = 8;
  localparam int QDEPTH        = 2;
  localparam int STRIKE_W      = 4;
  localparam int DISC_W        = 4;
  localparam int PHASE_W       = $clog2(SLOT_CYCLES);

  localparam logic [STRIKE_W-1:0] STRIKE_MAX = STRIKE_W'(15);
  localparam logic [PHASE_W-1:0]  PHASE_LAST = PHASE_W'(SLOT_CYCLES - 1);

  typedef struct packed {
    logic [DIM_W-1:0] h;
    logic [DIM_W-1:0] w;
  } req_t;

  typedef struct packed {
    logic [IDX_W-1:0] x;
    logic [IDX_W-1:0] y;
    logic             strike;
  } rsp_t;
endpackage

// File: rtl/place_fifo.sv
// Small synchronous FIFO; a push while full is only taken when a pop frees the slot.
module place_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end
endmodule

// File: rtl/placement_slot_sequencer.sv
// Samples one rectangle per slot, hands it to the placement core and publishes the
// core's answer at a fixed slot offset, independent of the core's own latency.
module placement_slot_sequencer
  import placement_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [DIM_W-1:0]    height_i,
  input  logic [DIM_W-1:0]    width_i,
  output logic                req_valid_o,
  output logic [DIM_W-1:0]    req_height_o,
  output logic [DIM_W-1:0]    req_width_o,
  input  logic                req_ready_i,
  input  logic                rsp_valid_i,
  input  logic [IDX_W-1:0]    rsp_x_i,
  input  logic [IDX_W-1:0]    rsp_y_i,
  input  logic                rsp_strike_i,
  output logic [IDX_W-1:0]    index_x_o,
  output logic [IDX_W-1:0]    index_y_o,
  output logic [STRIKE_W-1:0] strike_o,
  output logic                overrun_o
);
  logic [PHASE_W-1:0]       r_phase;
  logic [LATENCY_SLOTS-1:0] r_tag;
  logic [DISC_W-1:0]        r_discard;

  req_t w_req_in, w_req_head;
  rsp_t w_rsp_in, w_rsp_head;
  logic w_req_full, w_req_empty, w_rsp_full, w_rsp_empty;
  logic w_ph0, w_sample, w_req_pop, w_req_ovf, w_req_push;
  logic w_pub, w_rsp_pop, w_miss, w_rsp_drop, w_rsp_ovf, w_rsp_push;

  assign w_ph0      = (r_phase == '0);
  assign w_sample   = w_ph0 && (height_i != '0) && (width_i != '0);
  assign w_req_pop  = req_valid_o && req_ready_i;
  assign w_req_ovf  = w_sample && w_req_full && !w_req_pop;
  assign w_req_push = w_sample && !w_req_ovf;
  assign w_req_in   = '{h: height_i, w: width_i};

  assign w_pub      = w_ph0 && r_tag[LATENCY_SLOTS-1];
  assign w_rsp_pop  = w_pub && !w_rsp_empty;
  assign w_miss     = w_pub && w_rsp_empty;
  // A result arriving on the very edge its slot is missed is already late.
  assign w_rsp_drop = rsp_valid_i && ((r_discard != '0) || w_miss);
  assign w_rsp_ovf  = rsp_valid_i && !w_rsp_drop && w_rsp_full && !w_rsp_pop;
  assign w_rsp_push = rsp_valid_i && !w_rsp_drop && !w_rsp_ovf;
  assign w_rsp_in   = '{x: rsp_x_i, y: rsp_y_i, strike: rsp_strike_i};

  assign req_valid_o  = !w_req_empty;
  assign req_height_o = w_req_head.h;
  assign req_width_o  = w_req_head.w;

  place_fifo #(.WIDTH($bits(req_t)), .DEPTH(QDEPTH)) u_req_fifo (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_push  (w_req_push),
    .i_data  (w_req_in),
    .i_pop   (w_req_pop),
    .o_head  (w_req_head),
    .o_full  (w_req_full),
    .o_empty (w_req_empty)
  );

  place_fifo #(.WIDTH($bits(rsp_t)), .DEPTH(QDEPTH)) u_rsp_fifo (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_push  (w_rsp_push),
    .i_data  (w_rsp_in),
    .i_pop   (w_rsp_pop),
    .o_head  (w_rsp_head),
    .o_full  (w_rsp_full),
    .o_empty (w_rsp_empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_phase   <= '0;
      r_tag     <= '0;
      r_discard <= '0;
      index_x_o <= '0;
      index_y_o <= '0;
      strike_o  <= '0;
      overrun_o <= 1'b0;
    end else begin
      r_phase <= (r_phase == PHASE_LAST) ? '0 : r_phase + 1'b1;
      if (w_ph0) begin
        r_tag <= LATENCY_SLOTS'({r_tag, w_req_push});
      end

      if (w_rsp_pop) begin
        index_x_o <= w_rsp_head.x;
        index_y_o <= w_rsp_head.y;
        if (w_rsp_head.strike && (strike_o != STRIKE_MAX)) begin
          strike_o <= strike_o + 1'b1;
        end
      end

      if (w_miss || w_req_ovf || w_rsp_ovf) begin
        overrun_o <= 1'b1;
      end

      if (w_miss && !w_rsp_drop) begin
        if (r_discard != '1) begin
          r_discard <= r_discard + 1'b1;
        end
      end else if (w_rsp_drop && !w_miss) begin
        r_discard <= r_discard - 1'b1;
      end
    end
  end
endmodule
